// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side buffer.
// Each FIFO entry is either a received byte or an end-of-frame marker.
package uart_pkg;

  typedef struct packed {
    logic       eof;
    logic [7:0] data;
  } uart_rx_entry_t;

  localparam logic [7:0] UART_EOF_DATA = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// The head entry is visible on head_data whenever the FIFO is not empty.
module sync_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers received UART bytes and inserts an end-of-frame marker when the
// line goes idle after traffic; consumer side is FWFT valid/ready.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_available,
  input  logic                  rx_idle,
  output logic [7:0]            rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  uart_rx_entry_t push_entry;
  uart_rx_entry_t head_entry;
  logic           full;
  logic           empty;
  logic           pop;
  logic           can_push;
  logic           byte_push;
  logic           byte_drop;
  logic           marker_push;
  logic           idle_q;
  logic           idle_rise;
  logic           marker_pend;
  logic           byte_since_eof;

  assign rd_valid  = !empty;
  assign pop       = rd_valid && rd_ready;
  assign can_push  = !full || pop;
  assign idle_rise = rx_idle && !idle_q;

  // Incoming bytes always win the write port; a pending marker waits for a free cycle.
  assign byte_push   = rx_available && can_push;
  assign byte_drop   = rx_available && !can_push;
  assign marker_push = marker_pend && !rx_available && can_push;

  always_comb begin
    push_entry = '{eof: 1'b1, data: UART_EOF_DATA};
    if (rx_available) push_entry = '{eof: 1'b0, data: rx_data};
  end

  sync_fifo #(
    .WIDTH      ($bits(uart_rx_entry_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (byte_push || marker_push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rd_data = rd_valid ? head_entry.data : 8'h00;
  assign rd_last = rd_valid && head_entry.eof;

  // idle_q resets high so the line being idle at startup does not look like a frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q         <= 1'b1;
      marker_pend    <= 1'b0;
      byte_since_eof <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      idle_q <= rx_idle;

      if (byte_drop)           overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;

      if (marker_push)                        marker_pend <= 1'b0;
      else if (idle_rise && byte_since_eof)   marker_pend <= 1'b1;

      // Dropped bytes still count as traffic, so an overflowed frame is still terminated.
      if (rx_available)   byte_since_eof <= 1'b1;
      else if (idle_rise) byte_since_eof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected entries,
// a negedge monitor compares every accepted head entry.
module tb_uart_rx_buffer;

  localparam int DEPTH_LOG2 = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          rx_data;
  logic                rx_available;
  logic                rx_idle;
  logic [7:0]          rd_data;
  logic                rd_last;
  logic                rd_valid;
  logic                rd_ready;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clear_overflow;

  logic [8:0] expQ[$];
  logic [8:0] monExp;
  int         passCount = 0;
  int         checkCount = 0;

  uart_rx_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_available   (rx_available),
    .rx_idle        (rx_idle),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Every accepted head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL pop_unexpected: got last=%0b data=%h, required no entry", rd_last, rd_data);
      end else begin
        monExp = expQ.pop_front();
        if ({rd_last, rd_data} === monExp) passCount++;
        else $display("[TB] FAIL pop_entry: got last=%0b data=%h, required last=%0b data=%h",
                      rd_last, rd_data, monExp[8], monExp[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic avail, input logic [7:0] data, input logic idle,
                               input logic ready, input logic clr);
    rx_available   = avail;
    rx_data        = data;
    rx_idle        = idle;
    rd_ready       = ready;
    clear_overflow = clr;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic waitEmpty(input string name, input int budget);
    int n = 0;
    while (count != 0 && n < budget) begin
      applyStimulus(1'b0, 8'h00, rx_idle, 1'b1, 1'b0);
      n++;
    end
    checkOutput(name, 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    rx_available = 1'b0;
    rx_data = 8'h00;
    rx_idle = 1'b1;
    rd_ready = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_data", 32'(rd_data), 32'd0);
    checkOutput("reset_last", 32'(rd_last), 32'd0);

    $display("[TB] frame with two bytes then idle");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    expQ.push_back({1'b0, 8'h41});
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    expQ.push_back({1'b0, 8'h42});
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    expQ.push_back({1'b1, 8'h00});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    waitEmpty("frame1_drain", 20);
    checkOutput("frame1_queue_left", 32'(expQ.size()), 32'd0);

    $display("[TB] overflow with 17 bytes");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expQ.push_back({1'b0, 8'(8'h10 + i)});
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_head", 32'(rd_data), 32'h10);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    $display("[TB] push and pop while full");
    expQ.push_back({1'b0, 8'hA5});
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("fullpp_count", 32'(count), 32'd16);
    checkOutput("fullpp_overflow", 32'(overflow), 32'd0);

    $display("[TB] idle rise while full");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("fullidle_count", 32'(count), 32'd16);
    checkOutput("fullidle_head", 32'(rd_data), 32'h11);
    expQ.push_back({1'b1, 8'h00});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("marker_slot_count", 32'(count), 32'd16);
    waitEmpty("full_drain", 40);
    checkOutput("full_drain_valid", 32'(rd_valid), 32'd0);
    checkOutput("full_queue_left", 32'(expQ.size()), 32'd0);

    $display("[TB] idle toggles without bytes");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("nomarker_count", 32'(count), 32'd0);
    checkOutput("nomarker_valid", 32'(rd_valid), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expQ.push_back({1'b0, 8'(8'h60 + i)});
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_count", 32'(count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expQ.delete();
    checkOutput("post_reset_count", 32'(count), 32'd0);
    checkOutput("post_reset_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_nomarker", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
